// File: rtl/fsmc_reg_slave.sv
// Asynchronous FSMC bus slave: synchronises the strobes and issues one-cycle register strobes.
// Optional transaction timeout with DRAIN recovery is compiled in by defining FSMC_TIMEOUT_EN.
module fsmc_reg_slave #(
  parameter int unsigned ADRW    = 1,
  parameter int unsigned DATW    = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            aNE,
  input  logic            aNOE,
  input  logic            aNWE,
  input  logic [ADRW-1:0] aAn,
  input  logic [DATW-1:0] aDn,
  output logic [ADRW-1:0] rw_adr,
  output logic            do_write,
  output logic [DATW-1:0] w_data,
  output logic            do_read,
  input  logic [DATW-1:0] read_data,
  output logic            io_output,
  output logic [DATW-1:0] io_data,
  output logic            err_timeout
);

  if (TIMEOUT < 4 || TIMEOUT > 65535) begin : g_timeout_range
    $error("fsmc_reg_slave: TIMEOUT must lie in 4..65535");
  end

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StWrite = 5'b00010,
    StRead1 = 5'b00100,
    StRead2 = 5'b01000,
    StDrain = 5'b10000
  } state_e;

  state_e state_q, state_d;

  logic [1:0] ne_sync_q, noe_sync_q, nwe_sync_q;
  logic       ne_s, noe_s, nwe_s;

  logic [ADRW-1:0] rw_adr_q, rw_adr_d;
  logic [DATW-1:0] w_data_q, w_data_d;
  logic [DATW-1:0] io_data_q, io_data_d;
  logic            do_write_q, do_write_d;
  logic            do_read_q, do_read_d;
  logic            timeout_hit;

  // Synchronisers idle high so a bus held active across reset is only seen after two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ne_sync_q  <= 2'b11;
      noe_sync_q <= 2'b11;
      nwe_sync_q <= 2'b11;
    end else begin
      ne_sync_q  <= {ne_sync_q[0], aNE};
      noe_sync_q <= {noe_sync_q[0], aNOE};
      nwe_sync_q <= {nwe_sync_q[0], aNWE};
    end
  end

  assign ne_s  = ne_sync_q[1];
  assign noe_s = noe_sync_q[1];
  assign nwe_s = nwe_sync_q[1];

  // State register and registered datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rw_adr_q   <= '0;
      w_data_q   <= '0;
      io_data_q  <= '0;
      do_write_q <= 1'b0;
      do_read_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_adr_q   <= rw_adr_d;
      w_data_q   <= w_data_d;
      io_data_q  <= io_data_d;
      do_write_q <= do_write_d;
      do_read_q  <= do_read_d;
    end
  end

  // Next-state logic; write wins when both strobes are seen together in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!ne_s) begin
          if (!nwe_s) begin
            state_d = StWrite;
          end else if (!noe_s) begin
            state_d = StRead1;
          end
        end
      end
      StWrite: begin
        if (ne_s || nwe_s) begin
          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StDrain;
        end
      end
      StRead1: begin
        if (ne_s || noe_s) begin
          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StDrain;
        end else begin
          state_d = StRead2;
        end
      end
      StRead2: begin
        if (ne_s || noe_s) begin
          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (ne_s && noe_s && nwe_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and latch-point logic.
  always_comb begin
    do_write_d = (state_q == StIdle) && (state_d == StWrite);
    do_read_d  = (state_q == StIdle) && (state_d == StRead1);
    rw_adr_d   = rw_adr_q;
    w_data_d   = w_data_q;
    io_data_d  = io_data_q;
    if (do_write_d || do_read_d) begin
      rw_adr_d = aAn;
    end
    if (do_write_d) begin
      w_data_d = aDn;
    end
    if ((state_q == StRead1) && (state_d == StRead2)) begin
      io_data_d = read_data;
    end
    // Pad drive follows the synced strobes directly so it releases without an extra cycle.
    io_output = (state_q == StRead2) && !ne_s && !noe_s;
  end

`ifdef FSMC_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        active_d;

  assign active_d    = (state_d == StWrite) || (state_d == StRead1) || (state_d == StRead2);
  assign timeout_hit = (cnt_q == TimeoutCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (active_d) begin
      cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end
    err_d = (state_d == StDrain) && (state_q != StDrain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign rw_adr   = rw_adr_q;
  assign w_data   = w_data_q;
  assign io_data  = io_data_q;
  assign do_write = do_write_q;
  assign do_read  = do_read_q;

endmodule

// File: tb/tb_fsmc_reg_slave.sv
// Scoreboard bench for fsmc_reg_slave: expected strobes are queued at stimulus time and matched
// against strobes captured one time unit after each rising edge.
module tb_fsmc_reg_slave;
  localparam int ADRW = 2;
  localparam int DATW = 16;

  logic            clk = 1'b0;
  logic            rst, aNE, aNOE, aNWE;
  logic [ADRW-1:0] aAn, rw_adr;
  logic [DATW-1:0] aDn, w_data, read_data, io_data;
  logic            do_write, do_read, io_output, err_timeout;

  always #5 clk = ~clk;

  fsmc_reg_slave #(.ADRW(ADRW), .DATW(DATW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aAn(aAn), .aDn(aDn),
    .rw_adr(rw_adr), .do_write(do_write), .w_data(w_data), .do_read(do_read),
    .read_data(read_data), .io_output(io_output), .io_data(io_data), .err_timeout(err_timeout)
  );

  typedef struct {
    logic            rd;
    logic [ADRW-1:0] adr;
    logic [DATW-1:0] dat;
    int              cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int total = 0, bad = 0, cyc = 0;
  int io_rise_cyc = 0, io_fall_cyc = 0, io_rise_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [DATW-1:0] io_rise_data = '0;
  logic io_prev = 1'b0, err_io = 1'b0;

  task automatic push_exp(input logic rd, input logic [ADRW-1:0] adr, input logic [DATW-1:0] dat,
                          input int c);
    ev_t e;
    e.rd = rd; e.adr = adr; e.dat = dat; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Advances n rising edges, recording strobe and pad events seen just after each edge.
  task automatic run_cycles(input int n);
    ev_t o;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      if (do_write) begin
        o.rd = 1'b0; o.adr = rw_adr; o.dat = w_data; o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (do_read) begin
        o.rd = 1'b1; o.adr = rw_adr; o.dat = '0; o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (do_write && do_read) both_cnt++;
      if (io_output && !io_prev) begin
        io_rise_cyc = cyc; io_rise_data = io_data; io_rise_cnt++;
      end
      if (!io_output && io_prev) io_fall_cyc = cyc;
      io_prev = io_output;
      if (err_timeout) begin
        err_cnt++; err_io = io_output;
      end
    end
  endtask

  task automatic bus_release();
    @(negedge clk);
    aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
    aAn = '0; aDn = '0; read_data = '0;
    run_cycles(2);
    total++; if (rw_adr !== 2'd0) begin bad++; $display("FAIL rst_rw_adr: got %0h want 0", rw_adr); end
    total++; if (w_data !== 16'd0) begin bad++; $display("FAIL rst_w_data: got %0h want 0", w_data); end
    total++; if (io_data !== 16'd0) begin bad++; $display("FAIL rst_io_data: got %0h want 0", io_data); end
    total++; if ({do_write, do_read, io_output, err_timeout} !== 4'b0000) begin
      bad++; $display("FAIL rst_strobes: got %b want 0000", {do_write, do_read, io_output, err_timeout});
    end
    @(negedge clk);
    rst = 1'b0;
    run_cycles(4);
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL idle_quiet: got %0d strobes want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_write();
    ev_t e, o;
    int k;
    @(negedge clk);
    aAn = 2'd2; aDn = 16'hBEEF; aNE = 1'b0; aNWE = 1'b0;
    k = cyc + 1;
    push_exp(1'b0, 2'd2, 16'hBEEF, k + 2);
    run_cycles(10);
    bus_release();
    aAn = 2'd0; aDn = 16'h0000;
    run_cycles(5);
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rd !== e.rd || o.adr !== e.adr || o.dat !== e.dat || o.cyc !== e.cyc) begin
        bad++; $display("FAIL write_event: got rd=%0b adr=%0h dat=%0h cyc=%0d want rd=%0b adr=%0h dat=%0h cyc=%0d",
                        o.rd, o.adr, o.dat, o.cyc, e.rd, e.adr, e.dat, e.cyc);
      end
    end
    total++; if (w_data !== 16'hBEEF) begin bad++; $display("FAIL write_hold: got %0h want beef", w_data); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read();
    ev_t e, o;
    int k, r, rise0;
    rise0 = io_rise_cnt;
    @(negedge clk);
    aAn = 2'd1; read_data = 16'h1234; aNE = 1'b0; aNOE = 1'b0;
    k = cyc + 1;
    push_exp(1'b1, 2'd1, 16'h0000, k + 2);
    run_cycles(10);
    bus_release();
    r = cyc + 1;
    run_cycles(5);
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL read_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rd !== e.rd || o.adr !== e.adr || o.cyc !== e.cyc) begin
        bad++; $display("FAIL read_event: got rd=%0b adr=%0h cyc=%0d want rd=%0b adr=%0h cyc=%0d",
                        o.rd, o.adr, o.cyc, e.rd, e.adr, e.cyc);
      end
    end
    total++; if (io_rise_cnt !== rise0 + 1) begin bad++; $display("FAIL read_io_pulses: got %0d want %0d", io_rise_cnt - rise0, 1); end
    total++; if (io_rise_cyc !== k + 3) begin bad++; $display("FAIL read_io_rise: got %0d want %0d", io_rise_cyc, k + 3); end
    total++; if (io_rise_data !== 16'h1234) begin bad++; $display("FAIL read_io_data: got %0h want 1234", io_rise_data); end
    total++; if (io_fall_cyc !== r + 1) begin bad++; $display("FAIL read_io_fall: got %0d want %0d", io_fall_cyc, r + 1); end
    total++; if (rw_adr !== 2'd1 || io_data !== 16'h1234) begin
      bad++; $display("FAIL read_hold: got adr=%0h data=%0h want adr=1 data=1234", rw_adr, io_data);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    ev_t e, o;
    int k, rise0;
    rise0 = io_rise_cnt;
    @(negedge clk);
    aAn = 2'd3; aDn = 16'hA5A5; read_data = 16'h7777; aNE = 1'b0; aNOE = 1'b0; aNWE = 1'b0;
    k = cyc + 1;
    push_exp(1'b0, 2'd3, 16'hA5A5, k + 2);
    run_cycles(8);
    bus_release();
    run_cycles(5);
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL simul_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rd !== e.rd || o.adr !== e.adr || o.dat !== e.dat || o.cyc !== e.cyc) begin
        bad++; $display("FAIL simul_event: got rd=%0b adr=%0h dat=%0h cyc=%0d want rd=%0b adr=%0h dat=%0h cyc=%0d",
                        o.rd, o.adr, o.dat, o.cyc, e.rd, e.adr, e.dat, e.cyc);
      end
    end
    total++; if (io_rise_cnt !== rise0) begin bad++; $display("FAIL simul_io: got %0d pad enables want 0", io_rise_cnt - rise0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int k;
    @(negedge clk);
    aAn = 2'd1; aDn = 16'h1111; aNE = 1'b0; aNWE = 1'b0;
    k = cyc + 1;
    push_exp(1'b0, 2'd1, 16'h1111, k + 2);
    run_cycles(4);
    @(negedge clk);
    aNWE = 1'b1;
    run_cycles(3);
    @(negedge clk);
    aAn = 2'd3; aDn = 16'h2222; aNWE = 1'b0;
    k = cyc + 1;
    push_exp(1'b0, 2'd3, 16'h2222, k + 2);
    run_cycles(4);
    bus_release();
    run_cycles(5);
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rd !== e.rd || o.adr !== e.adr || o.dat !== e.dat || o.cyc !== e.cyc) begin
        bad++; $display("FAIL b2b_event: got rd=%0b adr=%0h dat=%0h cyc=%0d want rd=%0b adr=%0h dat=%0h cyc=%0d",
                        o.rd, o.adr, o.dat, o.cyc, e.rd, e.adr, e.dat, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    ev_t e, o;
    int k, err0;
    err0 = err_cnt;
    @(negedge clk);
    aAn = 2'd2; read_data = 16'h5678; aNE = 1'b0; aNOE = 1'b0;
    k = cyc + 1;
    push_exp(1'b1, 2'd2, 16'h0000, k + 2);
    run_cycles(30);
`ifdef FSMC_TIMEOUT_EN
    total++; if (err_cnt !== err0 + 1) begin bad++; $display("FAIL to_err_pulses: got %0d want 1", err_cnt - err0); end
    total++; if (err_io !== 1'b0) begin bad++; $display("FAIL to_io_at_err: got %b want 0", err_io); end
    total++; if (io_output !== 1'b0) begin bad++; $display("FAIL to_io_drain: got %b want 0", io_output); end
    bus_release();
    run_cycles(5);
    @(negedge clk);
    aAn = 2'd1; read_data = 16'h9ABC; aNE = 1'b0; aNOE = 1'b0;
    k = cyc + 1;
    push_exp(1'b1, 2'd1, 16'h0000, k + 2);
    run_cycles(6);
    total++; if (io_output !== 1'b1 || io_data !== 16'h9ABC) begin
      bad++; $display("FAIL to_recover: got io=%b data=%0h want io=1 data=9abc", io_output, io_data);
    end
`else
    total++; if (err_cnt !== err0) begin bad++; $display("FAIL to_err_off: got %0d pulses want 0", err_cnt - err0); end
    total++; if (io_output !== 1'b1 || io_data !== 16'h5678) begin
      bad++; $display("FAIL to_long_read: got io=%b data=%0h want io=1 data=5678", io_output, io_data);
    end
`endif
    bus_release();
    run_cycles(5);
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL to_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rd !== e.rd || o.adr !== e.adr || o.cyc !== e.cyc) begin
        bad++; $display("FAIL to_event: got rd=%0b adr=%0h cyc=%0d want rd=%0b adr=%0h cyc=%0d",
                        o.rd, o.adr, o.cyc, e.rd, e.adr, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    int k;
    @(negedge clk);
    aAn = 2'd2; aDn = 16'hCAFE; read_data = 16'h0F0F; aNE = 1'b0; aNOE = 1'b0;
    k = cyc + 1;
    push_exp(1'b1, 2'd2, 16'h0000, k + 2);
    run_cycles(5);
    total++; if (io_output !== 1'b1) begin bad++; $display("FAIL rm_pre_io: got %b want 1", io_output); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (io_output !== 1'b0) begin bad++; $display("FAIL rm_io_now: got %b want 0", io_output); end
    total++; if ({do_write, do_read, err_timeout} !== 3'b000) begin
      bad++; $display("FAIL rm_strobes: got %b want 000", {do_write, do_read, err_timeout});
    end
    total++; if (rw_adr !== 2'd0 || w_data !== 16'd0 || io_data !== 16'd0) begin
      bad++; $display("FAIL rm_regs: got adr=%0h wd=%0h io=%0h want 0 0 0", rw_adr, w_data, io_data);
    end
    run_cycles(2);
    @(negedge clk);
    rst = 1'b0;
    k = cyc + 1;
    push_exp(1'b1, 2'd2, 16'h0000, k + 2);
    run_cycles(6);
    total++; if (io_output !== 1'b1 || io_data !== 16'h0F0F) begin
      bad++; $display("FAIL rm_new_read: got io=%b data=%0h want io=1 data=0f0f", io_output, io_data);
    end
    bus_release();
    run_cycles(5);
    total++; if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rm_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rd !== e.rd || o.adr !== e.adr || o.cyc !== e.cyc) begin
        bad++; $display("FAIL rm_event: got rd=%0b adr=%0h cyc=%0d want rd=%0b adr=%0h cyc=%0d",
                        o.rd, o.adr, o.cyc, e.rd, e.adr, e.cyc);
      end
    end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL no_overlap: got %0d overlapping strobes want 0", both_cnt); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
